// File: rtl/dmem_bridge_pkg.sv
// Shared definitions for the core-to-memory bridges: state encoding and error read data.
package dmem_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } bridge_state_e;

    localparam logic [31:0] ERR_RDATA_DEF = 32'h0000_0000;

endpackage

// File: rtl/dmem_timeout_ctr.sv
// Cycle counter for the bus timeout: cleared by load, counts while enabled,
// and flags the terminal count TERM-1.
module dmem_timeout_ctr #(
    parameter int CNT_W = 5,
    parameter int TERM  = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TERM - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/dmem_bridge.sv
// Data-memory bridge: turns single-cycle core loads/stores into req/ack bus
// transactions, stalling the core until the access completes or is aborted.
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 16,
    parameter int          CNT_W          = 5,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    input  logic        core_read,
    input  logic        core_write,
    output logic [31:0] core_rdata,
    output logic        core_stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    input  logic        err_clr,
    output logic        err_flag
);

    bridge_state_e state_q;
    logic          bus_req_q, bus_we_q, err_flag_q;
    logic [31:0]   bus_addr_q, bus_wdata_q, core_rdata_q;
    logic          access, timeout;

    assign access = core_read | core_write;

    dmem_timeout_ctr #(
        .CNT_W (CNT_W),
        .TERM  (TIMEOUT_CYCLES)
    ) u_tmo (
        .clk    (clk),
        .reset  (reset),
        .load_i (state_q == IDLE),
        .en_i   ((state_q == BUSY) && !bus_ack),
        .tc_o   (timeout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            core_rdata_q <= '0;
            err_flag_q   <= 1'b0;
        end else begin
            // Clear first so a same-cycle set below takes priority.
            if (err_clr) err_flag_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (access) begin
                        if (core_addr[1:0] == 2'b00) begin
                            bus_addr_q  <= core_addr;
                            bus_wdata_q <= core_wdata;
                            bus_we_q    <= core_write;
                            bus_req_q   <= 1'b1;
                            state_q     <= BUSY;
                        end else begin
                            err_flag_q   <= 1'b1;
                            core_rdata_q <= ERR_RDATA;
                            state_q      <= DONE;
                        end
                    end
                end
                BUSY: begin
                    if (bus_ack) begin
                        if (!bus_we_q) core_rdata_q <= bus_rdata;
                        bus_req_q <= 1'b0;
                        state_q   <= DONE;
                    end else if (timeout) begin
                        bus_req_q    <= 1'b0;
                        err_flag_q   <= 1'b1;
                        core_rdata_q <= ERR_RDATA;
                        state_q      <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        core_stall = 1'b0;
        case (state_q)
            IDLE:    core_stall = access;
            BUSY:    core_stall = 1'b1;
            default: core_stall = 1'b0;
        endcase
    end

    assign bus_req    = bus_req_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;
    assign core_rdata = core_rdata_q;
    assign err_flag   = err_flag_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: hand-computed expectations checked with
// immediate assertions at fixed points 1ns after each rising edge.
module tb_dmem_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] core_addr, core_wdata, core_rdata, bus_addr, bus_wdata, bus_rdata;
    logic        core_read, core_write, core_stall, bus_req, bus_we, bus_ack;
    logic        err_clr, err_flag;

    int nchk = 0;
    int nerr = 0;
    int stalls;
    int req_starts = 0;
    int starts0;
    logic req_prev = 1'b0;

    always #5 clk = ~clk;

    dmem_bridge dut (
        .clk        (clk),
        .reset      (reset),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_read  (core_read),
        .core_write (core_write),
        .core_rdata (core_rdata),
        .core_stall (core_stall),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata),
        .err_clr    (err_clr),
        .err_flag   (err_flag)
    );

    // Count distinct bus transactions (rising edges of bus_req seen at clock edges).
    always @(posedge clk) begin
        if (bus_req && !req_prev) req_starts <= req_starts + 1;
        req_prev <= bus_req;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; core_addr = '0; core_wdata = '0; core_read = 1'b0; core_write = 1'b0;
        bus_ack = 1'b0; bus_rdata = '0; err_clr = 1'b0;
        tick(); tick();
        chk("rst_req", bus_req, 0);
        chk("rst_we", bus_we, 0);
        chk("rst_err", err_flag, 0);
        chk("rst_rdata", core_rdata, 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_stall", core_stall, 0);
        reset = 1'b0;
        tick();

        // 1: aligned read, ack in first BUSY cycle
        starts0 = req_starts;
        core_addr = 32'h10; core_read = 1'b1; #1;
        chk("rd_idle_stall", core_stall, 1);
        tick();
        chk("rd_req", bus_req, 1);
        chk("rd_addr", bus_addr, 32'h10);
        chk("rd_we", bus_we, 0);
        chk("rd_busy_stall", core_stall, 1);
        bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
        tick();
        bus_ack = 1'b0; bus_rdata = '0;
        chk("rd_done_stall", core_stall, 0);
        chk("rd_data", core_rdata, 32'hCAFE_F00D);
        chk("rd_done_req", bus_req, 0);
        chk("rd_err", err_flag, 0);
        tick();
        core_read = 1'b0; #1;
        chk("rd_noreissue", bus_req, 0);
        chk("rd_one_txn", req_starts - starts0, 1);

        // 2: write with 4 wait cycles
        starts0 = req_starts; stalls = 0;
        core_addr = 32'h20; core_wdata = 32'h1234_5678; core_write = 1'b1; #1;
        if (core_stall) stalls++;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (core_stall) stalls++;
            chk("wr_req", bus_req, 1);
            chk("wr_we", bus_we, 1);
            chk("wr_wdata", bus_wdata, 32'h1234_5678);
            chk("wr_addr", bus_addr, 32'h20);
            if (i == 5) begin
                bus_ack = 1'b1; bus_rdata = 32'hBAD0_BAD0;
            end
        end
        tick();
        bus_ack = 1'b0; bus_rdata = '0;
        chk("wr_done_stall", core_stall, 0);
        chk("wr_stall_cycles", stalls, 6);
        chk("wr_rdata_kept", core_rdata, 32'hCAFE_F00D);
        tick();
        core_write = 1'b0; #1;
        chk("wr_one_txn", req_starts - starts0, 1);

        // 3: misaligned read
        starts0 = req_starts;
        core_addr = 32'h13; core_read = 1'b1; #1;
        chk("mis_stall", core_stall, 1);
        tick();
        chk("mis_req", bus_req, 0);
        chk("mis_rdata", core_rdata, 0);
        chk("mis_err", err_flag, 1);
        chk("mis_done_stall", core_stall, 0);
        tick();
        core_read = 1'b0;
        tick();
        chk("mis_err_held", err_flag, 1);
        chk("mis_no_txn", req_starts - starts0, 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("mis_err_clr", err_flag, 0);

        // 6: ack in the same cycle as the timeout
        core_addr = 32'h50; core_read = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk("tie_req", bus_req, 1);
            if (i == 16) begin
                bus_ack = 1'b1; bus_rdata = 32'hA5A5_5A5A;
            end
        end
        tick();
        bus_ack = 1'b0; bus_rdata = '0;
        chk("tie_data", core_rdata, 32'hA5A5_5A5A);
        chk("tie_err", err_flag, 0);
        chk("tie_req_drop", bus_req, 0);
        tick();
        core_read = 1'b0;

        // 4: timeout, no ack
        core_addr = 32'h30; core_read = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk("tmo_req", bus_req, 1);
        end
        tick();
        chk("tmo_req_drop", bus_req, 0);
        chk("tmo_err", err_flag, 1);
        chk("tmo_rdata", core_rdata, 0);
        chk("tmo_done_stall", core_stall, 0);
        core_read = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        tick(); tick();
        bus_ack = 1'b0; bus_rdata = '0;
        chk("late_ack_rdata", core_rdata, 0);
        chk("late_ack_req", bus_req, 0);
        chk("late_ack_err", err_flag, 1);

        // 5: reset during BUSY (err_flag still set from the timeout)
        core_addr = 32'h60; core_read = 1'b1;
        tick();
        chk("rb_req", bus_req, 1);
        #2;
        reset = 1'b1; core_read = 1'b0; #1;
        chk("rb_req_async", bus_req, 0);
        chk("rb_err", err_flag, 0);
        tick();
        reset = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA;
        tick();
        bus_ack = 1'b0; bus_rdata = '0;
        chk("rb_ack_ign_req", bus_req, 0);
        chk("rb_ack_ign_stall", core_stall, 0);
        chk("rb_ack_ign_rdata", core_rdata, 0);
        core_addr = 32'h40; core_read = 1'b1;
        tick();
        chk("rb2_req", bus_req, 1);
        chk("rb2_addr", bus_addr, 32'h40);
        bus_ack = 1'b1; bus_rdata = 32'h1122_3344;
        tick();
        bus_ack = 1'b0; bus_rdata = '0;
        chk("rb2_data", core_rdata, 32'h1122_3344);
        chk("rb2_err", err_flag, 0);
        chk("rb2_stall", core_stall, 0);
        tick();
        core_read = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
